// File: rtl/mod7_seq_checker.sv
// Receiving-end monitor for the START-gated 000->110 counter: tracks the
// expected state, decodes the observed state, flags errors and counts laps.
module mod7_seq_checker #(
    parameter int unsigned LAP_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             STEP,
    input  logic [2:0]       STATE_IN,
    input  logic             CLEAR,
    output logic [6:0]       DECODE,
    output logic             SYNCED,
    output logic             WRAP,
    output logic [LAP_W-1:0] LAPS,
    output logic             ERR,
    output logic [2:0]       ERR_STATE,
    output logic [2:0]       ERR_EXP
);

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         exp_q, exp_d;
    logic [6:0]         decode_q, decode_d;
    logic               wrap_q, wrap_d;
    logic [LAP_W-1:0]   laps_q, laps_d;
    logic               err_q, err_d;
    logic [2:0]         err_state_q, err_state_d;
    logic [2:0]         err_exp_q, err_exp_d;
    logic [2:0]         exp_adv;

    function automatic logic [2:0] next7(input logic [2:0] s);
        return (s == 3'd6) ? 3'd0 : s + 3'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        wrap_d      = 1'b0;
        laps_d      = laps_q;
        err_d       = err_q;
        err_state_d = err_state_q;
        err_exp_d   = err_exp_q;
        // 111 shifts out of the 7-bit field, leaving an all-zero decode
        decode_d    = 7'd1 << STATE_IN;
        exp_adv     = STEP ? next7(exp_q) : exp_q;

        if (CLEAR) begin
            state_d     = HUNT;
            exp_d       = 3'd0;
            laps_d      = '0;
            err_d       = 1'b0;
            err_state_d = 3'd0;
            err_exp_d   = 3'd0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (STATE_IN == 3'd0) begin
                        exp_d   = STEP ? 3'd1 : 3'd0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (STATE_IN == exp_q) begin
                        exp_d = exp_adv;
                        if (exp_q == 3'd6 && STEP) begin
                            wrap_d = 1'b1;
                            if (laps_q != '1) begin
                                laps_d = laps_q + 1'b1;
                            end
                        end
                    end else begin
                        state_d     = FAULT;
                        err_d       = 1'b1;
                        err_state_d = STATE_IN;
                        err_exp_d   = exp_q;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            exp_q       <= 3'd0;
            decode_q    <= 7'd0;
            wrap_q      <= 1'b0;
            laps_q      <= '0;
            err_q       <= 1'b0;
            err_state_q <= 3'd0;
            err_exp_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            decode_q    <= decode_d;
            wrap_q      <= wrap_d;
            laps_q      <= laps_d;
            err_q       <= err_d;
            err_state_q <= err_state_d;
            err_exp_q   <= err_exp_d;
        end
    end

    assign DECODE    = decode_q;
    assign SYNCED    = (state_q == TRACK);
    assign WRAP      = wrap_q;
    assign LAPS      = laps_q;
    assign ERR       = err_q;
    assign ERR_STATE = err_state_q;
    assign ERR_EXP   = err_exp_q;

endmodule

// File: tb/tb_mod7_seq_checker.sv
// Scoreboard bench: a counter model drives the checker, a reference model
// queues expected outputs, and a monitor pops and compares every update.
module tb_mod7_seq_checker;

    typedef struct packed {
        logic [6:0] dec;
        logic       syn;
        logic       wrap;
        logic [7:0] laps;
        logic [1:0] laps2;
        logic       err;
        logic [2:0] es;
        logic [2:0] ee;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       step;
    logic       clear;
    logic [2:0] state_in;

    logic [6:0] dec, dec2;
    logic       syn, syn2, wrap, wrap2, err, err2;
    logic [7:0] laps;
    logic [1:0] laps2;
    logic [2:0] es, ee, es2, ee2;

    always #5 clock = ~clock;

    mod7_seq_checker dut (
        .clock(clock), .reset(reset), .STEP(step),
        .STATE_IN(state_in), .CLEAR(clear),
        .DECODE(dec), .SYNCED(syn), .WRAP(wrap), .LAPS(laps),
        .ERR(err), .ERR_STATE(es), .ERR_EXP(ee)
    );

    mod7_seq_checker #(.LAP_W(2)) dut2 (
        .clock(clock), .reset(reset), .STEP(step),
        .STATE_IN(state_in), .CLEAR(clear),
        .DECODE(dec2), .SYNCED(syn2), .WRAP(wrap2), .LAPS(laps2),
        .ERR(err2), .ERR_STATE(es2), .ERR_EXP(ee2)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;

    // reference model: mode 0 hunt, 1 track, 2 fault
    int m_mode, m_exp, m_laps, m_laps2, m_err, m_es, m_ee;
    int cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_laps = 0; m_laps2 = 0;
        m_err = 0; m_es = 0; m_ee = 0;
    endtask

    task automatic model_edge(input int st, input int s, input int clr,
                              output exp_t e);
        int w;
        w = 0;
        if (clr != 0) begin
            m_mode = 0; m_exp = 0; m_laps = 0; m_laps2 = 0;
            m_err = 0; m_es = 0; m_ee = 0;
        end else if (m_mode == 0) begin
            if (s == 0) begin
                m_exp  = st;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (s == m_exp) begin
                if (m_exp == 6 && st != 0) begin
                    w = 1;
                    if (m_laps < 255) m_laps++;
                    if (m_laps2 < 3) m_laps2++;
                end
                m_exp = (m_exp + st) % 7;
            end else begin
                m_mode = 2; m_err = 1; m_es = s; m_ee = m_exp;
            end
        end
        e.dec   = (s == 7) ? 7'd0 : 7'(2 ** s);
        e.syn   = (m_mode == 1);
        e.wrap  = (w != 0);
        e.laps  = 8'(m_laps);
        e.laps2 = 2'(m_laps2);
        e.err   = (m_err != 0);
        e.es    = 3'(m_es);
        e.ee    = 3'(m_ee);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock or negedge reset);
            #1;
            if (started) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("decode", dec, e.dec);
                    chk("synced", syn, e.syn);
                    chk("wrap", wrap, e.wrap);
                    chk("laps", laps, e.laps);
                    chk("err", err, e.err);
                    chk("err_state", es, e.es);
                    chk("err_exp", ee, e.ee);
                    chk("laps_w2", laps2, e.laps2);
                    chk("wrap_w2", wrap2, e.wrap);
                    chk("err_w2", err2, e.err);
                end
            end
        end
    end

    initial begin : driver
        exp_t e;
        int   st, s, clr, inj, rst, v;
        bit   clean;
        reset    = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
        state_in = 3'd0;
        model_reset();
        repeat (3) @(negedge clock);
        started = 1;
        q.push_back(zero_exp());
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!reset) reset = 1'b1;
            clean = (i < 10);
            st    = clean ? 1 : (($urandom_range(0, 9) < 7) ? 1 : 0);
            if (clean) clr = 0;
            else if (m_mode == 2) clr = ($urandom_range(0, 5) == 0);
            else clr = ($urandom_range(0, 199) == 0);
            inj = !clean && ($urandom_range(0, 59) == 0);
            rst = !clean && ($urandom_range(0, 299) == 0);
            s   = cnt;
            if (inj != 0) begin
                v = $urandom_range(0, 7);
                s = (v == cnt) ? 7 : v;
            end
            step     = st[0];
            clear    = clr[0];
            state_in = 3'(s);
            cnt      = (cnt + st) % 7;
            if (rst != 0) begin
                model_reset();
                q.push_back(zero_exp());
                q.push_back(zero_exp());
                #2 reset = 1'b0;
            end else begin
                model_edge(st, s, clr, e);
                q.push_back(e);
            end
        end
        @(posedge clock);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
